// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the command-master FSM encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  // States in which the master is waiting on the slave.
  function automatic logic is_bus_wait(state_e s);
    return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Saturating cycle counter that flags when a bus transaction has waited TIMEOUT cycles.
// TIMEOUT = 0 disables the watchdog.
module axil_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default the next value first so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: one read/write transaction per command,
// result returned on a valid/ready response port. All outputs are registered.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  // AXI-Lite write channels
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI-Lite read channels
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic wd_en;
  logic wd_expired;
  logic do_timeout;

  assign cmd_accept = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
  assign wd_en      = is_bus_wait(state_q);

  axil_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_accept),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    do_timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      // AW and W complete independently; awaddr stays put for slaves sampling it at W time.
      ST_WR: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = bresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
        end
      end

      ST_RD_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
        end
      end

      ST_RD_DATA: begin
        if (rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = rdata;
          rsp_resp_d    = rresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abandon the transaction: a handshake in the same cycle has already taken precedence above.
    if (do_timeout) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RSP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign awaddr      = awaddr_q;
  assign araddr      = araddr_q;
  assign wdata       = wdata_q;
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
